// File: rtl/pipe_pack16to32.sv
//------------------------------------------------------------------------------
// Module   : pipe_pack16to32
// Purpose  : Packs pairs of 16-bit valid/ready beats into registered 32-bit
//            words, flushes odd packet tails with padding and a keep mask.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_pack16to32 #(
    parameter logic [15:0] PAD_VALUE = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_vld,
    output logic        in_rdy,
    input  logic [15:0] in_data,
    input  logic        in_last,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic [31:0] out_data,
    output logic [1:0]  out_keep,
    output logic        out_last,
    output logic [15:0] pkt_cnt
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] hold_reg;
    logic [15:0] hold_nxt;
    logic        in_fire;
    logic        out_fire;
    logic        load_out;
    logic [31:0] word_nxt;
    logic [1:0]  keep_nxt;
    logic        last_nxt;

    // A new beat is only taken when the output register can accept a word,
    // so a completing beat can never be lost behind a stalled output.
    assign in_rdy   = ~out_vld | out_rdy;
    assign in_fire  = in_vld & in_rdy;
    assign out_fire = out_vld & out_rdy;

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_reg;
        load_out  = 1'b0;
        word_nxt  = {in_data, hold_reg};
        keep_nxt  = 2'b11;
        last_nxt  = in_last;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    if (in_last) begin
                        load_out = 1'b1;
                        word_nxt = {PAD_VALUE, in_data};
                        keep_nxt = 2'b01;
                        last_nxt = 1'b1;
                    end else begin
                        hold_nxt  = in_data;
                        state_nxt = HALF;
                    end
                end
            end
            HALF: begin
                if (in_fire) begin
                    load_out  = 1'b1;
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            hold_reg <= 16'h0000;
        end else begin
            state    <= state_nxt;
            hold_reg <= hold_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_data <= 32'h0000_0000;
            out_keep <= 2'b00;
            out_last <= 1'b0;
        end else if (in_rdy) begin
            out_vld <= load_out;
            if (load_out) begin
                out_data <= word_nxt;
                out_keep <= keep_nxt;
                out_last <= last_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt <= 16'h0000;
        end else if (out_fire && out_last) begin
            pkt_cnt <= pkt_cnt + 16'h0001;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_pack16to32.sv
//------------------------------------------------------------------------------
// Module   : tb_pipe_pack16to32
// Purpose  : Directed and randomized self-checking bench for pipe_pack16to32.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_pack16to32;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        in_vld  = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        in_last = 1'b0;
    logic        out_rdy = 1'b1;
    logic        in_rdy;
    logic        out_vld;
    logic [31:0] out_data;
    logic [1:0]  out_keep;
    logic        out_last;
    logic [15:0] pkt_cnt;

    int total = 0;
    int bad   = 0;

    logic [63:0] got_q[$];
    logic [63:0] exp_q[$];
    logic        m_half = 1'b0;
    logic [15:0] m_hold = 16'h0000;
    logic [15:0] m_pkts = 16'h0000;
    bit          rnd_rdy = 1'b0;

    pipe_pack16to32 #(.PAD_VALUE(16'h0000)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_keep (out_keep),
        .out_last (out_last),
        .pkt_cnt  (pkt_cnt)
    );

    always #5 clk = ~clk;

    // Inputs only move just after the rising edge, so the falling edge sees
    // exactly what the next rising edge will act on.
    always @(negedge clk) begin
        if (rst_n && out_vld && out_rdy)
            got_q.push_back({29'd0, out_last, out_keep, out_data});
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rnd_rdy) out_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    function automatic logic [63:0] wd(input logic l, input logic [1:0] k, input logic [31:0] d);
        return {29'd0, l, k, d};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [63:0] exp);
        if (got_q.size() == 0) chk({tag, "_missing"}, 64'd0, exp);
        else chk(tag, got_q.pop_front(), exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_vld  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input logic l, output int waits);
        bit fired;
        in_vld  = 1'b1;
        in_data = d;
        in_last = l;
        waits   = 0;
        fired   = 1'b0;
        while (!fired && waits < 200) begin
            @(negedge clk);
            fired = in_rdy;
            tick();
            if (!fired) waits++;
        end
        if (!fired) begin
            total++;
            bad++;
            $error("FAIL send_timeout observed=stalled expected=accepted data=%h", d);
        end else if (m_half) begin
            exp_q.push_back(wd(l, 2'b11, {d, m_hold}));
            m_half = 1'b0;
            if (l) m_pkts++;
        end else if (l) begin
            exp_q.push_back(wd(1'b1, 2'b01, {16'h0000, d}));
            m_pkts++;
        end else begin
            m_half = 1'b1;
            m_hold = d;
        end
    endtask

    task automatic drain();
        int g;
        out_rdy = 1'b1;
        g = 0;
        while (out_vld && g < 50) begin
            tick();
            g++;
        end
        if (out_vld) chk("drain_timeout", 64'(out_vld), 64'd0);
        tick();
        tick();
    endtask

    initial begin
        int w;
        int stalls;
        int left;
        int n;

        // Reset values
        tick();
        tick();
        chk("rst_out_vld",  64'(out_vld),  64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_keep", 64'(out_keep), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_pkt_cnt",  64'(pkt_cnt),  64'd0);
        chk("rst_in_rdy",   64'(in_rdy),   64'd1);
        rst_n = 1'b1;
        tick();

        // Even packet
        send(16'h1111, 1'b0, w);
        send(16'h2222, 1'b0, w);
        send(16'h3333, 1'b0, w);
        send(16'h4444, 1'b1, w);
        idle();
        drain();
        pop_chk("even_w0", wd(1'b0, 2'b11, 32'h2222_1111));
        pop_chk("even_w1", wd(1'b1, 2'b11, 32'h4444_3333));
        chk("even_pkt_cnt", 64'(pkt_cnt), 64'd1);

        // Single-beat packet, one-cycle latency
        send(16'h5A5A, 1'b1, w);
        chk("single_vld",  64'(out_vld),  64'd1);
        chk("single_data", 64'(out_data), 64'h0000_5A5A);
        chk("single_keep", 64'(out_keep), 64'd1);
        chk("single_last", 64'(out_last), 64'd1);
        idle();
        drain();
        pop_chk("single_w", wd(1'b1, 2'b01, 32'h0000_5A5A));

        // Odd packet
        send(16'hAAAA, 1'b0, w);
        send(16'hBBBB, 1'b0, w);
        send(16'hCCCC, 1'b1, w);
        idle();
        drain();
        pop_chk("odd_w0", wd(1'b0, 2'b11, 32'hBBBB_AAAA));
        pop_chk("odd_w1", wd(1'b1, 2'b01, 32'h0000_CCCC));
        chk("odd_pkt_cnt", 64'(pkt_cnt), 64'd3);

        // Backpressure with a pending word
        out_rdy = 1'b0;
        send(16'h0A0A, 1'b0, w);
        send(16'h0B0B, 1'b0, w);
        in_vld  = 1'b1;
        in_data = 16'h0C0C;
        in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_rdy", 64'(in_rdy), 64'd0);
            chk("bp_data",   64'(out_data), 64'h0B0B_0A0A);
            tick();
        end
        out_rdy = 1'b1;
        send(16'h0C0C, 1'b0, w);
        send(16'h0D0D, 1'b1, w);
        idle();
        drain();
        pop_chk("bp_w0", wd(1'b0, 2'b11, 32'h0B0B_0A0A));
        pop_chk("bp_w1", wd(1'b1, 2'b11, 32'h0D0D_0C0C));
        chk("bp_extra_words", 64'(got_q.size()), 64'd0);

        // Reset mid-packet
        send(16'h1234, 1'b0, w);
        idle();
        rst_n = 1'b0;
        #1;
        chk("mrst_out_vld", 64'(out_vld), 64'd0);
        chk("mrst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk("mrst_state",   64'(dut.state), 64'd0);
        tick();
        rst_n  = 1'b1;
        m_half = 1'b0;
        m_pkts = 16'h0000;
        tick();
        send(16'h0001, 1'b0, w);
        send(16'h0002, 1'b1, w);
        idle();
        drain();
        pop_chk("mrst_w0", wd(1'b1, 2'b11, 32'h0002_0001));
        chk("mrst_extra_words", 64'(got_q.size()), 64'd0);

        // Back-to-back full rate
        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            send(16'h0100 + 16'(i), (i == 7), w);
            stalls += w;
        end
        idle();
        drain();
        chk("b2b_stalls", 64'(stalls), 64'd0);
        chk("b2b_words",  64'(got_q.size()), 64'd4);
        pop_chk("b2b_w0", wd(1'b0, 2'b11, 32'h0101_0100));
        pop_chk("b2b_w1", wd(1'b0, 2'b11, 32'h0103_0102));
        pop_chk("b2b_w2", wd(1'b0, 2'b11, 32'h0105_0104));
        pop_chk("b2b_w3", wd(1'b1, 2'b11, 32'h0107_0106));
        chk("b2b_pkt_cnt", 64'(pkt_cnt), 64'd2);

        // Random valid/ready against the reference model
        got_q.delete();
        exp_q.delete();
        rnd_rdy = 1'b1;
        left = 0;
        for (int b = 0; b < 1000; b++) begin
            logic l;
            if (left == 0) left = $urandom_range(1, 5);
            if ($urandom_range(0, 3) == 0) begin
                idle();
                repeat ($urandom_range(1, 2)) tick();
            end
            l = (left == 1) || (b == 999);
            send(16'($urandom), l, w);
            left = l ? 0 : left - 1;
        end
        idle();
        rnd_rdy = 1'b0;
        drain();
        chk("rnd_count", 64'(got_q.size()), 64'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk("rnd_word", got_q.pop_front(), exp_q.pop_front());
        chk("rnd_pkt_cnt", 64'(pkt_cnt), 64'(m_pkts));

        // pkt_cnt wrap
        n = 16'hFFFF - m_pkts;
        for (int i = 0; i < n; i++) begin
            send(16'(i), 1'b1, w);
            if ((i & 1023) == 0) begin
                got_q.delete();
                exp_q.delete();
            end
        end
        idle();
        drain();
        chk("wrap_ffff", 64'(pkt_cnt), 64'hFFFF);
        send(16'hBEEF, 1'b1, w);
        idle();
        drain();
        chk("wrap_zero", 64'(pkt_cnt), 64'h0000);
        got_q.delete();
        exp_q.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_pack16to32.md
# pipe_pack16to32

Width-packing stage placed directly downstream of the 16-bit valid/ready pipeline register. It collects pairs of 16-bit beats into one 32-bit word and presents that word on a registered valid/ready output. A packet terminated on an odd beat is flushed as a half word, padded and marked with a keep mask. The block also counts completed packets for status readback.

## Interface
- PAD_VALUE, 16'h0000, value placed in the upper half of a flushed odd word
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_vld  input  1  upstream beat valid
- in_rdy  output  1  block can accept a beat this cycle
- in_data  input  16  upstream beat payload
- in_last  input  1  beat is the final beat of a packet
- out_vld  output  1  registered 32-bit word valid
- out_rdy  input  1  downstream accepts word
- out_data  output  32  packed word; first beat in [15:0], second beat in [31:16]
- out_keep  output  2  half-word valid mask: bit0 = [15:0], bit1 = [31:16]
- out_last  output  1  word ends a packet
- pkt_cnt  output  16  count of words transferred with out_last=1, wraps 16'hFFFF -> 0

## Operation
- Handshake fire conditions: in_fire = in_vld & in_rdy; out_fire = out_vld & out_rdy.
- in_rdy = ~out_vld | out_rdy, combinational, in every state.
- State machine, 2 states:
  - EMPTY: no half word held.
  - HALF: low half held in hold_reg.
- EMPTY + in_fire + ~in_last: hold_reg <= in_data; go to HALF; output register not loaded.
- EMPTY + in_fire + in_last: load output with out_data = {PAD_VALUE, in_data}, keep = 2'b01, last = 1; stay in EMPTY.
- HALF + in_fire: load output with out_data = {in_data, hold_reg}, keep = 2'b11, last = in_last; go to EMPTY.
- Output register update is enabled when (~out_vld | out_rdy):
  - out_vld <= in_fire & (state==HALF | in_last).
  - data/keep/last load only when that expression is 1; otherwise they hold.
- A packet of N beats yields ceil(N/2) words. Only the final word carries last. keep=2'b01 appears only on an odd-length final word.
- pkt_cnt increments by 1 on each out_fire with out_last=1.
- No state changes without in_fire. in_vld while in_rdy=0 has no effect. Upstream must hold its beat until in_rdy.

## Timing
- Reset values: out_vld=0, out_data=0, out_keep=0, out_last=0, pkt_cnt=0, state=EMPTY, hold_reg=0. in_rdy=1 while in reset because out_vld=0.
- Reset asserted mid-packet discards the held half word and any pending output word. No flush occurs.
- Latency: the word appears on out_vld one cycle after the in_fire that completes it. That is the second beat of a pair, or a last beat in EMPTY.
- Throughput: 1 input beat per cycle sustained while out_rdy=1, which gives 1 output word per 2 cycles. An odd last beat gives 1 word for that single cycle.
- Simultaneous out_fire and completing in_fire in one cycle: the old word leaves and the new word loads. out_vld stays 1 with no bubble.
- out_rdy=0 with out_vld=1:
  - in_rdy=0.
  - out_data, out_keep and out_last stay stable until out_fire.
  - state and hold_reg are frozen.
- pkt_cnt wraps silently at 16'hFFFF -> 0 and is updated the cycle after out_fire.

## Test plan
- Even packet, out_rdy=1:
  - Stimulus: beats 16'h1111, 16'h2222, 16'h3333, 16'h4444 (last).
  - Response: 32'h2222_1111 keep 11 last 0, then 32'h4444_3333 keep 11 last 1; pkt_cnt=1.
- Odd packets:
  - Stimulus: beats 16'hAAAA, 16'hBBBB, 16'hCCCC (last).
  - Response: 32'hBBBB_AAAA keep 11, then 32'h0000_CCCC keep 01 last 1.
  - Stimulus: single-beat packet 16'h5A5A (last).
  - Response: 32'h0000_5A5A keep 01 last 1 one cycle after in_fire.
- Backpressure:
  - Stimulus: hold out_rdy=0 for 5 cycles with a word pending.
  - Response: in_rdy=0; out_data unchanged for all 5 cycles.
  - Stimulus: release out_rdy.
  - Response: the word transfers and the next pair resumes with no lost or duplicated beats. Random in_vld/out_rdy over 1000 beats matches the reference model.
- Reset mid-packet:
  - Stimulus: accept 16'h1234 (not last), pulse rst_n low.
  - Response: out_vld=0, pkt_cnt=0, state=EMPTY.
  - Stimulus: beats 16'h0001, 16'h0002 (last).
  - Response: 32'h0002_0001 keep 11, with no 16'h1234 in the output.
- pkt_cnt wrap:
  - Stimulus: preload pkt_cnt by sending 65535 single-beat packets, then one more.
  - Response: pkt_cnt reads 16'hFFFF then 16'h0000.
- Back-to-back full rate:
  - Stimulus: continuous in_vld with out_rdy=1 for 8 beats (last on beat 8).
  - Response: in_rdy=1 every cycle; 4 words output; out_vld never stalls the input.
